// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer with 16x baud tick, configurable frame format and back-to-back loading
module uart_tx_ctrl (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        reg_ctrl_thr_vld,
  input  logic [7:0]  reg_ctrl_thr_data,
  input  logic [15:0] reg_ctrl_dllh_data,
  input  logic        reg_ctrl_set_dllh_vld,
  input  logic [1:0]  reg_ctrl_lcr_dls,
  input  logic        reg_ctrl_lcr_pen,
  input  logic        reg_ctrl_lcr_eps,
  input  logic        reg_ctrl_lcr_stop,
  output logic        ctrl_reg_thr_read,
  output logic        ctrl_reg_thsr_empty,
  output logic        ctrl_reg_tx_busy,
  output logic        uart_txd
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [5:0]  tick_cnt_q, tick_cnt_d, bit_len;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d, mask;
  logic [1:0]  dls_q, dls_d;
  logic        pen_q, pen_d, stop_q, stop_d, par_q, par_d;
  logic        txd_q, txd_d;
  logic        n_zero, tick, bit_end, last_data, load, shift_en;
  always_comb begin
    n_zero     = reg_ctrl_dllh_data == 16'd0;
    tick       = !n_zero && (div_q >= reg_ctrl_dllh_data - 16'd1);
    bit_len    = state_q == STOP ? (stop_q ? (dls_q == 2'd0 ? 6'd24 : 6'd32) : 6'd16) : 6'd16;
    bit_end    = tick && (tick_cnt_q == bit_len - 6'd1);
    last_data  = bit_cnt_q == ({1'b0, dls_q} + 3'd4);
    load       = reg_ctrl_thr_vld && !n_zero && (state_q == IDLE || (state_q == STOP && bit_end));
    shift_en   = state_q == DATA && bit_end;
    mask       = 8'hFF >> (2'd3 - reg_ctrl_lcr_dls);
    div_d      = (reg_ctrl_set_dllh_vld || load || n_zero || tick) ? 16'd0 : div_q + 16'd1;
    tick_cnt_d = (reg_ctrl_set_dllh_vld || load || bit_end || state_q == IDLE) ? 6'd0 :
                 tick ? tick_cnt_q + 6'd1 : tick_cnt_q;
    bit_cnt_d  = load ? 3'd0 : shift_en ? bit_cnt_q + 3'd1 : bit_cnt_q;
    shift_d    = load ? reg_ctrl_thr_data : shift_en ? shift_q >> 1 : shift_q;
    dls_d      = load ? reg_ctrl_lcr_dls : dls_q;
    pen_d      = load ? reg_ctrl_lcr_pen : pen_q;
    stop_d     = load ? reg_ctrl_lcr_stop : stop_q;
    par_d      = load ? (^(reg_ctrl_thr_data & mask)) ^ ~reg_ctrl_lcr_eps : par_q;
    state_d    = state_q;
    case (state_q)
      IDLE:    if (load) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && last_data) state_d = pen_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end) state_d = load ? START : IDLE;
      default: state_d = IDLE;
    endcase
    // txd is registered from the upcoming state so the line changes exactly on the bit boundary edge
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
  end
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      dls_q      <= '0;
      pen_q      <= 1'b0;
      stop_q     <= 1'b0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      dls_q      <= dls_d;
      pen_q      <= pen_d;
      stop_q     <= stop_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
    end
  end
  assign ctrl_reg_thr_read   = load;
  assign ctrl_reg_thsr_empty = state_q == IDLE;
  assign ctrl_reg_tx_busy    = state_q != IDLE || reg_ctrl_thr_vld;
  assign uart_txd            = txd_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: per-cycle waveform model of UART frames plus directed cases with literal expectations
module tb_uart_tx_ctrl;
  logic        sys_clk = 1'b0, rst = 1'b1, vld = 1'b0, set_n = 1'b0;
  logic        pen = 1'b0, eps = 1'b0, stp = 1'b0;
  logic [7:0]  thr = 8'h00;
  logic [15:0] n = 16'd0;
  logic [1:0]  dls = 2'd3;
  logic        thr_read, thsr_empty, tx_busy, uart_txd;
  int          checks = 0, errors = 0, cyc = 0;
  logic        wave[$];
  logic        hist_t[$];
  logic        hist_e[$];
  int          reads[$];

  uart_tx_ctrl dut (
    .sys_clk(sys_clk), .rst(rst),
    .reg_ctrl_thr_vld(vld), .reg_ctrl_thr_data(thr),
    .reg_ctrl_dllh_data(n), .reg_ctrl_set_dllh_vld(set_n),
    .reg_ctrl_lcr_dls(dls), .reg_ctrl_lcr_pen(pen), .reg_ctrl_lcr_eps(eps), .reg_ctrl_lcr_stop(stp),
    .ctrl_reg_thr_read(thr_read), .ctrl_reg_thsr_empty(thsr_empty),
    .ctrl_reg_tx_busy(tx_busy), .uart_txd(uart_txd)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: the queue holds the txd value of every remaining cycle of the frame(s) in flight
  always @(negedge sys_clk) begin : model
    logic popped, e_txd, e_read;
    int ones, len;
    hist_t.push_back(uart_txd);
    hist_e.push_back(thsr_empty);
    if (thr_read) reads.push_back(cyc);
    if (rst) begin
      wave.delete();
      popped = 1'b0;
      e_txd  = 1'b1;
      e_read = 1'b0;
    end else begin
      popped = wave.size() != 0;
      e_txd  = popped ? wave.pop_front() : 1'b1;
      e_read = vld && n != 16'd0 && wave.size() == 0;
    end
    chk("txd", uart_txd, e_txd);
    chk("thr_read", thr_read, e_read);
    chk("thsr_empty", thsr_empty, !popped);
    chk("tx_busy", tx_busy, popped || vld);
    if (e_read) begin
      ones = 0;
      repeat (16 * n) wave.push_back(1'b0);
      for (int i = 0; i < 5 + dls; i++) begin
        ones += thr[i];
        repeat (16 * n) wave.push_back(thr[i]);
      end
      if (pen) repeat (16 * n) wave.push_back(eps ? ones[0] : !ones[0]);
      len = !stp ? 16 : (dls == 2'd0 ? 24 : 32);
      repeat (len * n) wave.push_back(1'b1);
    end
    cyc++;
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    thr = b;
    vld = 1'b1;
    t = 0;
    do begin
      @(negedge sys_clk);
      t++;
    end while (!thr_read && t < 3000);
    if (t >= 3000) chk("read_timeout", 0, 1);
    @(posedge sys_clk);
    #1;
    vld = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!thsr_empty && t < 5000) begin
      cycles(1);
      t++;
    end
    if (t >= 5000) chk("idle_timeout", 0, 1);
    cycles(2);
  endtask

  task automatic cfg(input logic [15:0] nn, input logic [1:0] d, input logic p, input logic e, input logic s);
    n = nn; dls = d; pen = p; eps = e; stp = s;
  endtask

  // Samples the middle of each bit of a frame that was loaded at cycle r; lit lists bits in line order, MSB first
  task automatic bits_at(input string name, input int r, input int per, input logic [15:0] lit, input int cnt);
    for (int i = 0; i < cnt; i++) chk(name, hist_t[r + 1 + i * per + per / 2], lit[cnt - 1 - i]);
  endtask

  initial begin
    int r, r1, nr, z;
    cycles(3);
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_empty", thsr_empty, 1'b1);
    chk("rst_read", thr_read, 1'b0);
    rst = 1'b0;
    cycles(2);

    cfg(16'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    nr = reads.size();
    send(8'h55);
    wait_idle();
    r = reads[$];
    chk("t1_reads", reads.size() - nr, 1);
    bits_at("t1_bit", r, 16, 16'b0101010101, 10);
    chk("t1_busy_end", hist_e[r + 160], 1'b0);
    chk("t1_empty_end", hist_e[r + 161], 1'b1);

    cfg(16'd2, 2'd2, 1'b1, 1'b1, 1'b0);
    send(8'h41);
    wait_idle();
    r = reads[$];
    bits_at("t2_bit", r, 32, 16'b0100000101, 10);
    chk("t2_busy_end", hist_e[r + 320], 1'b0);
    chk("t2_empty_end", hist_e[r + 321], 1'b1);

    cfg(16'd1, 2'd0, 1'b1, 1'b0, 1'b1);
    send(8'h1F);
    wait_idle();
    r = reads[$];
    bits_at("t3_bit", r, 16, 16'b01111101, 8);
    chk("t3_busy_end", hist_e[r + 136], 1'b0);
    chk("t3_empty_end", hist_e[r + 137], 1'b1);

    cfg(16'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    nr = reads.size();
    send(8'hA5);
    send(8'h3C);
    wait_idle();
    chk("t4_reads", reads.size() - nr, 2);
    r1 = reads[nr];
    r  = reads[nr + 1];
    chk("t4_gap", r - r1, 160);
    chk("t4_start2", hist_t[r1 + 161], 1'b0);
    chk("t4_no_idle", hist_e[r1 + 161], 1'b0);

    cfg(16'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    nr = reads.size();
    thr = 8'h0F;
    vld = 1'b1;
    cycles(20);
    chk("t5_busy", tx_busy, 1'b1);
    chk("t5_txd", uart_txd, 1'b1);
    chk("t5_empty", thsr_empty, 1'b1);
    chk("t5_no_read", reads.size() - nr, 0);
    n = 16'd3;
    set_n = 1'b1;
    #1;
    chk("t5_read_now", thr_read, 1'b1);
    cycles(1);
    set_n = 1'b0;
    vld = 1'b0;
    wait_idle();
    r = reads[$];
    chk("t5_reads", reads.size() - nr, 1);
    chk("t5_start_last", hist_t[r + 48], 1'b0);
    chk("t5_bit0_first", hist_t[r + 49], 1'b1);
    bits_at("t5_bit", r, 48, 16'b0111100001, 10);

    cfg(16'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    send(8'h00);
    cycles(40);
    chk("t6_in_data", uart_txd, 1'b0);
    chk("t6_busy", thsr_empty, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_txd", uart_txd, 1'b1);
    chk("t6_rst_empty", thsr_empty, 1'b1);
    cycles(3);
    rst = 1'b0;
    nr = reads.size();
    r1 = cyc;
    cycles(200);
    z = 0;
    for (int i = r1; i < cyc; i++) z += (hist_t[i] == 1'b0) ? 1 : 0;
    chk("t6_line_idle", z, 0);
    chk("t6_no_read", reads.size() - nr, 0);
    chk("t6_empty", thsr_empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
